// File: rtl/iicmb_seq_pkg.sv
// Shared definitions for the IICMB command sequencer: register map, CMDR
// command codes, completion status encoding, FSM state types and status decode.
package iicmb_seq_pkg;

    localparam logic [1:0] REG_CSR  = 2'd0;
    localparam logic [1:0] REG_DPR  = 2'd1;
    localparam logic [1:0] REG_CMDR = 2'd2;
    localparam logic [1:0] REG_FSMR = 2'd3;

    localparam logic [2:0] CMD_START   = 3'b100;
    localparam logic [2:0] CMD_STOP    = 3'b101;
    localparam logic [2:0] CMD_WRITE   = 3'b001;
    localparam logic [2:0] CMD_READACK = 3'b010;
    localparam logic [2:0] CMD_READNAK = 3'b011;
    localparam logic [2:0] CMD_SETBUS  = 3'b110;

    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_NAK = 2'b01,
        ST_AL  = 2'b10,
        ST_ERR = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENABLE = 3'd1,
        S_SETBUS = 3'd2,
        S_START  = 3'd3,
        S_ADDR   = 3'd4,
        S_DATA   = 3'd5,
        S_STOP   = 3'd6,
        S_DONE   = 3'd7
    } seq_state_e;

    typedef enum logic [1:0] {
        OP_WR  = 2'd0,
        OP_RD  = 2'd1,
        OP_CMD = 2'd2
    } op_kind_e;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_BUS  = 2'd1,
        P_IRQ  = 2'd2
    } port_state_e;

    // Arbitration loss outranks error, error outranks NAK; no flag at all is an error.
    function automatic status_e cmdr_status(input logic [7:0] cmdr);
        status_e res;
        if (cmdr[5]) begin
            res = ST_AL;
        end else if (cmdr[4]) begin
            res = ST_ERR;
        end else if (cmdr[6]) begin
            res = ST_NAK;
        end else if (cmdr[7]) begin
            res = ST_OK;
        end else begin
            res = ST_ERR;
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_cmd_port.sv
// Single Wishbone master port: plain register write/read, or a CMDR command
// write followed by an irq wait and one CMDR readback.
module wb_cmd_port
    import iicmb_seq_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 2,
    parameter int WB_DATA_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     go_i,
    input  op_kind_e                 kind_i,
    input  logic [WB_ADDR_WIDTH-1:0] adr_i,
    input  logic [WB_DATA_WIDTH-1:0] wdat_i,
    output logic                     done_o,
    output logic [WB_DATA_WIDTH-1:0] rdata_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);

    port_state_e               pst_r, pst_s;
    logic                      cyc_r, cyc_s;
    logic                      we_r, we_s;
    logic                      cmd_r, cmd_s;
    logic                      done_r, done_s;
    logic [WB_ADDR_WIDTH-1:0]  adr_r, adr_s;
    logic [WB_DATA_WIDTH-1:0]  dat_r, dat_s;
    logic [WB_DATA_WIDTH-1:0]  rdata_r, rdata_s;

    // Port state and all bus outputs are registered; reset drops the bus at once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pst_r   <= P_IDLE;
            cyc_r   <= 1'b0;
            we_r    <= 1'b0;
            cmd_r   <= 1'b0;
            done_r  <= 1'b0;
            adr_r   <= {WB_ADDR_WIDTH{1'b0}};
            dat_r   <= {WB_DATA_WIDTH{1'b0}};
            rdata_r <= {WB_DATA_WIDTH{1'b0}};
        end else begin
            pst_r   <= pst_s;
            cyc_r   <= cyc_s;
            we_r    <= we_s;
            cmd_r   <= cmd_s;
            done_r  <= done_s;
            adr_r   <= adr_s;
            dat_r   <= dat_s;
            rdata_r <= rdata_s;
        end
    end

    // Next-state: every cycle ends the registered bus cycle the edge after ack.
    always_comb begin
        pst_s   = pst_r;
        cyc_s   = cyc_r;
        we_s    = we_r;
        cmd_s   = cmd_r;
        done_s  = 1'b0;
        adr_s   = adr_r;
        dat_s   = dat_r;
        rdata_s = rdata_r;
        case (pst_r)
            P_IDLE: begin
                if (go_i) begin
                    cyc_s = 1'b1;
                    we_s  = (kind_i != OP_RD);
                    cmd_s = (kind_i == OP_CMD);
                    adr_s = adr_i;
                    dat_s = wdat_i;
                    pst_s = P_BUS;
                end else begin
                    pst_s = P_IDLE;
                end
            end
            P_BUS: begin
                if (ack_i) begin
                    cyc_s = 1'b0;
                    we_s  = 1'b0;
                    adr_s = {WB_ADDR_WIDTH{1'b0}};
                    dat_s = {WB_DATA_WIDTH{1'b0}};
                    if (!we_r) begin
                        rdata_s = dat_i;
                        done_s  = 1'b1;
                        pst_s   = P_IDLE;
                    end else if (cmd_r) begin
                        pst_s = P_IRQ;
                    end else begin
                        done_s = 1'b1;
                        pst_s  = P_IDLE;
                    end
                end else begin
                    pst_s = P_BUS;
                end
            end
            P_IRQ: begin
                if (irq_i) begin
                    cyc_s = 1'b1;
                    we_s  = 1'b0;
                    cmd_s = 1'b0;
                    adr_s = WB_ADDR_WIDTH'(REG_CMDR);
                    pst_s = P_BUS;
                end else begin
                    pst_s = P_IRQ;
                end
            end
            default: begin
                pst_s = P_IDLE;
                cyc_s = 1'b0;
                we_s  = 1'b0;
            end
        endcase
    end

    assign cyc_o   = cyc_r;
    assign stb_o   = cyc_r;
    assign we_o    = we_r;
    assign adr_o   = adr_r;
    assign dat_o   = dat_r;
    assign done_o  = done_r;
    assign rdata_o = rdata_r;

endmodule

// File: rtl/i2c_wb_sequencer.sv
// Turns one I2C read/write request into the IICMB register command sequence
// (enable, set bus, start, address, data bytes, stop) over Wishbone.
module i2c_wb_sequencer
    import iicmb_seq_pkg::*;
#(
    parameter int         WB_ADDR_WIDTH = 2,
    parameter int         WB_DATA_WIDTH = 8,
    parameter logic [7:0] CSR_ENABLE    = 8'hC0
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [3:0]               req_bus_i,
    input  logic [6:0]               req_addr_i,
    input  logic                     req_rd_i,
    input  logic [7:0]               req_len_i,
    input  logic                     wdata_valid_i,
    output logic                     wdata_ready_o,
    input  logic [7:0]               wdata_i,
    output logic                     rdata_valid_o,
    output logic [7:0]               rdata_o,
    output logic                     done_o,
    output logic [1:0]               status_o,
    output logic                     busy_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);

    seq_state_e state_r, state_s;
    logic       step_r, step_s;
    logic       pending_r, pending_s;
    logic       enabled_r, enabled_s;
    logic [3:0] bus_r, bus_s;
    logic [6:0] addr_r, addr_s;
    logic       rd_r, rd_s;
    logic [7:0] len_r, len_s;
    logic [7:0] cnt_r, cnt_s;
    status_e    status_r, status_s;

    logic       req_ready_r, busy_r, done_r, rdv_r, wrdy_r;
    logic       done_s, rdv_s, wrdy_s;
    logic [1:0] status_out_r, status_out_s;
    logic [7:0] rdata_r, rdata_s;

    logic                     want_s, go_s, last_s;
    op_kind_e                 kind_s;
    logic [WB_ADDR_WIDTH-1:0] adr_s;
    logic [WB_DATA_WIDTH-1:0] wdat_s;
    logic                     port_done;
    logic [WB_DATA_WIDTH-1:0] port_rdata;
    status_e                  res_s;

    wb_cmd_port #(
        .WB_ADDR_WIDTH (WB_ADDR_WIDTH),
        .WB_DATA_WIDTH (WB_DATA_WIDTH)
    ) u_port (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .go_i    (go_s),
        .kind_i  (kind_s),
        .adr_i   (adr_s),
        .wdat_i  (wdat_s),
        .done_o  (port_done),
        .rdata_o (port_rdata),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .we_o    (we_o),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .dat_i   (dat_i),
        .ack_i   (ack_i),
        .irq_i   (irq_i)
    );

    // Sequencer state, latched request and registered handshake/completion outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r      <= S_IDLE;
            step_r       <= 1'b0;
            pending_r    <= 1'b0;
            enabled_r    <= 1'b0;
            bus_r        <= 4'd0;
            addr_r       <= 7'd0;
            rd_r         <= 1'b0;
            len_r        <= 8'd0;
            cnt_r        <= 8'd0;
            status_r     <= ST_OK;
            req_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            rdv_r        <= 1'b0;
            wrdy_r       <= 1'b0;
            status_out_r <= 2'b00;
            rdata_r      <= 8'd0;
        end else begin
            state_r      <= state_s;
            step_r       <= step_s;
            pending_r    <= pending_s;
            enabled_r    <= enabled_s;
            bus_r        <= bus_s;
            addr_r       <= addr_s;
            rd_r         <= rd_s;
            len_r        <= len_s;
            cnt_r        <= cnt_s;
            status_r     <= status_s;
            req_ready_r  <= (state_s == S_IDLE);
            busy_r       <= (state_s != S_IDLE);
            done_r       <= done_s;
            rdv_r        <= rdv_s;
            wrdy_r       <= wrdy_s;
            status_out_r <= status_out_s;
            rdata_r      <= rdata_s;
        end
    end

    // Each state issues up to two port operations (step 0/1); pending marks one in flight.
    always_comb begin
        state_s      = state_r;
        step_s       = step_r;
        pending_s    = pending_r;
        enabled_s    = enabled_r;
        bus_s        = bus_r;
        addr_s       = addr_r;
        rd_s         = rd_r;
        len_s        = len_r;
        cnt_s        = cnt_r;
        status_s     = status_r;
        done_s       = 1'b0;
        rdv_s        = 1'b0;
        wrdy_s       = 1'b0;
        status_out_s = status_out_r;
        rdata_s      = rdata_r;
        want_s       = 1'b0;
        go_s         = 1'b0;
        kind_s       = OP_WR;
        adr_s        = {WB_ADDR_WIDTH{1'b0}};
        wdat_s       = {WB_DATA_WIDTH{1'b0}};
        last_s       = (cnt_r == (len_r - 8'd1));
        res_s        = cmdr_status(8'(port_rdata));

        case (state_r)
            S_IDLE: begin
                if (req_valid_i && req_ready_r) begin
                    bus_s    = req_bus_i;
                    addr_s   = req_addr_i;
                    rd_s     = req_rd_i;
                    len_s    = req_len_i;
                    cnt_s    = 8'd0;
                    step_s   = 1'b0;
                    status_s = ST_OK;
                    state_s  = enabled_r ? S_SETBUS : S_ENABLE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ENABLE: begin
                want_s = 1'b1;
                adr_s  = WB_ADDR_WIDTH'(REG_CSR);
                wdat_s = WB_DATA_WIDTH'(CSR_ENABLE);
            end
            S_SETBUS: begin
                want_s = 1'b1;
                kind_s = step_r ? OP_CMD : OP_WR;
                adr_s  = step_r ? WB_ADDR_WIDTH'(REG_CMDR) : WB_ADDR_WIDTH'(REG_DPR);
                wdat_s = step_r ? WB_DATA_WIDTH'(CMD_SETBUS) : WB_DATA_WIDTH'({4'd0, bus_r});
            end
            S_START: begin
                want_s = 1'b1;
                kind_s = OP_CMD;
                adr_s  = WB_ADDR_WIDTH'(REG_CMDR);
                wdat_s = WB_DATA_WIDTH'(CMD_START);
            end
            S_ADDR: begin
                want_s = 1'b1;
                kind_s = step_r ? OP_CMD : OP_WR;
                adr_s  = step_r ? WB_ADDR_WIDTH'(REG_CMDR) : WB_ADDR_WIDTH'(REG_DPR);
                wdat_s = step_r ? WB_DATA_WIDTH'(CMD_WRITE) : WB_DATA_WIDTH'({addr_r, rd_r});
            end
            S_DATA: begin
                if (rd_r) begin
                    want_s = 1'b1;
                    kind_s = step_r ? OP_RD : OP_CMD;
                    adr_s  = step_r ? WB_ADDR_WIDTH'(REG_DPR) : WB_ADDR_WIDTH'(REG_CMDR);
                    wdat_s = last_s ? WB_DATA_WIDTH'(CMD_READNAK) : WB_DATA_WIDTH'(CMD_READACK);
                end else begin
                    want_s = step_r | wdata_valid_i;
                    kind_s = step_r ? OP_CMD : OP_WR;
                    adr_s  = step_r ? WB_ADDR_WIDTH'(REG_CMDR) : WB_ADDR_WIDTH'(REG_DPR);
                    wdat_s = step_r ? WB_DATA_WIDTH'(CMD_WRITE) : WB_DATA_WIDTH'(wdata_i);
                end
            end
            S_STOP: begin
                want_s = 1'b1;
                kind_s = OP_CMD;
                adr_s  = WB_ADDR_WIDTH'(REG_CMDR);
                wdat_s = WB_DATA_WIDTH'(CMD_STOP);
            end
            S_DONE: begin
                done_s       = 1'b1;
                status_out_s = status_r;
                state_s      = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        if (!pending_r && want_s) begin
            go_s      = 1'b1;
            pending_s = 1'b1;
            wrdy_s    = (state_r == S_DATA) && !rd_r && !step_r;
        end else begin
            go_s = 1'b0;
        end

        // A failed command outside STOP aborts: NAK still sends Stop, AL/ERR do not.
        if (pending_r && port_done) begin
            pending_s = 1'b0;
            if ((kind_s == OP_CMD) && (res_s != ST_OK) && (state_r != S_STOP)) begin
                status_s = res_s;
                step_s   = 1'b0;
                state_s  = (res_s == ST_NAK) ? S_STOP : S_DONE;
            end else begin
                case (state_r)
                    S_ENABLE: begin
                        enabled_s = 1'b1;
                        step_s    = 1'b0;
                        state_s   = S_SETBUS;
                    end
                    S_SETBUS: begin
                        step_s  = ~step_r;
                        state_s = step_r ? S_START : S_SETBUS;
                    end
                    S_START: begin
                        step_s  = 1'b0;
                        state_s = S_ADDR;
                    end
                    S_ADDR: begin
                        step_s  = ~step_r;
                        cnt_s   = 8'd0;
                        state_s = (step_r && (len_r == 8'd0)) ? S_STOP :
                                  (step_r ? S_DATA : S_ADDR);
                    end
                    S_DATA: begin
                        step_s = ~step_r;
                        if (step_r) begin
                            cnt_s   = cnt_r + 8'd1;
                            state_s = last_s ? S_STOP : S_DATA;
                            rdv_s   = rd_r;
                            rdata_s = rd_r ? 8'(port_rdata) : rdata_r;
                        end else begin
                            cnt_s = cnt_r;
                        end
                    end
                    S_STOP: begin
                        status_s = ((status_r == ST_OK) && (res_s != ST_OK)) ? res_s : status_r;
                        state_s  = S_DONE;
                    end
                    default: begin
                        state_s = state_r;
                    end
                endcase
            end
        end else begin
            step_s = step_s;
        end
    end

    assign req_ready_o   = req_ready_r;
    assign busy_o        = busy_r;
    assign done_o        = done_r;
    assign status_o      = status_out_r;
    assign rdata_valid_o = rdv_r;
    assign rdata_o       = rdata_r;
    assign wdata_ready_o = wrdy_r;

endmodule
